imem_responder: RTL

//   Instruction-memory responder: the memory end of the core's fetch interface. Serves one
//   64-bit fetch packet per cycle (two 32-bit instructions) from a 10-bit word address with

---
 rtl/imem_responder.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/imem_responder.sv
// Purpose     : instruction-memory end of the fetch interface; serves a 64-bit fetch packet
//               (two 32-bit instructions) per cycle and accepts program images byte-serially.
// Latency     : fetch data appears one cycle after addr_i is sampled with en_i=1.
// Backpressure: ld_ready_o is high for the whole LOAD state, so bytes are only held off
//               outside a session; ld_valid_i gaps simply stall assembly.
//
// Ports
//   clock_i     rising-edge clock for all state
//   reset_i     asynchronous active-high reset (array contents are not cleared)
//   addr_i      fetch word address
//   en_i        1 = capture mem[addr_i] into data_o, 0 = hold data_o (fetch stall)
//   sr_i        synchronous flush of data_o to a NOP pair
//   data_o      {inst1[63:32], inst0[31:0]}, inst0 is the lower-address instruction
//   ld_start_i  start a load session (only honoured in IDLE)
//   ld_base_i   first word address written by the session
//   ld_len_i    number of 64-bit words in the session (0 .. 2**AW)
//   ld_valid_i  ld_byte_i carries a byte
//   ld_byte_i   load byte, little-endian within each word
//   ld_ready_o  loader takes a byte this cycle
//   ld_busy_o   session active (LOAD or DONE)
//   ld_done_o   one-cycle pulse at session end

module imem_responder #(
    parameter int          AW  = 10,
    parameter logic [31:0] NOP = 32'h00000013
) (
    input  logic          clock_i,
    input  logic          reset_i,
    input  logic [AW-1:0] addr_i,
    input  logic          en_i,
    input  logic          sr_i,
    output logic [63:0]   data_o,
    input  logic          ld_start_i,
    input  logic [AW-1:0] ld_base_i,
    input  logic [AW:0]   ld_len_i,
    input  logic          ld_valid_i,
    input  logic [7:0]    ld_byte_i,
    output logic          ld_ready_o,
    output logic          ld_busy_o,
    output logic          ld_done_o
);

    localparam int DEPTH = 1 << AW;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q;
    state_t        state_d;

    logic [AW-1:0] waddr_q;
    logic [AW:0]   remaining_q;
    logic [2:0]    byte_cnt_q;
    logic [63:0]   asm_q;

    logic [63:0]   mem [0:DEPTH-1];

    logic          take;
    logic          word_done;
    logic          last_word;
    logic [63:0]   wr_word;

    // A byte is consumed only in LOAD; ld_ready_o already implies LOAD but the
    // explicit state term keeps the write enable tied to the FSM directly.
    assign take      = (state_q == S_LOAD) & ld_valid_i & ld_ready_o;
    assign word_done = take & (byte_cnt_q == 3'd7);
    assign last_word = (remaining_q == {{AW{1'b0}}, 1'b1});

    // The eighth byte goes straight into the top lane so the word can be
    // written on the same edge that accepts it.
    always_comb begin
        wr_word         = asm_q;
        wr_word[63:56]  = ld_byte_i;
    end

    // ---------------------------------------------------------------------
    // Loader FSM
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (ld_start_i) begin
                    state_d = (ld_len_i != '0) ? S_LOAD : S_DONE;
                end
            end
            S_LOAD: begin
                if (word_done && last_word) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Status outputs are registered alongside the state so they are clean
    // flop outputs that track the state exactly.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            ld_ready_o <= 1'b0;
            ld_busy_o  <= 1'b0;
            ld_done_o  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ld_ready_o <= (state_d == S_LOAD);
            ld_busy_o  <= (state_d != S_IDLE);
            ld_done_o  <= (state_d == S_DONE);
        end
    end

    // ---------------------------------------------------------------------
    // Loader datapath: write pointer, word countdown, byte assembly
    // ---------------------------------------------------------------------
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            waddr_q     <= '0;
            remaining_q <= '0;
            byte_cnt_q  <= '0;
            asm_q       <= '0;
        end else begin
            if ((state_q == S_IDLE) && ld_start_i) begin
                waddr_q     <= ld_base_i;
                remaining_q <= ld_len_i;
                byte_cnt_q  <= '0;
            end else if (take) begin
                asm_q[{byte_cnt_q, 3'b000} +: 8] <= ld_byte_i;
                // 3-bit counter wraps 7 -> 0 at the end of each word.
                byte_cnt_q <= byte_cnt_q + 3'd1;
                if (word_done) begin
                    // Address wraps modulo the array depth by width alone.
                    waddr_q     <= waddr_q + {{(AW-1){1'b0}}, 1'b1};
                    remaining_q <= remaining_q - {{AW{1'b0}}, 1'b1};
                end
            end
        end
    end

    // Array write port: no reset on the storage itself.
    always_ff @(posedge clock_i) begin
        if (word_done) begin
            mem[waddr_q] <= wr_word;
        end
    end

    // ---------------------------------------------------------------------
    // Fetch read port
    // ---------------------------------------------------------------------
    // While a session is active the output is pinned to NOPs, which also
    // guarantees a fetch never observes a half-written array.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            data_o <= {NOP, NOP};
        end else if (ld_busy_o) begin
            data_o <= {NOP, NOP};
        end else if (sr_i) begin
            data_o <= {NOP, NOP};
        end else if (en_i) begin
            data_o <= mem[addr_i];
        end
    end

endmodule
